mem_stage_lsu: RTL and testbench

- MEM pipeline stage for the MIPS core. It replaces the async single-port RAM access with a request/grant/rvalid handshake to an external data memory.
- Generalised in data width (32/64), address depth and byte-lane handling: true sub-word stores via byte enables, correct load extraction with sign or zero extension, and misalignment detection.
- Stalls the upstream pipeline while a memory op is in flight. Registers results into the MEM/WB boundary.

---
 rtl/mem_stage_pkg.sv | 52 +++++
 rtl/lsu_load_align.sv | 34 +++
 rtl/mem_stage_lsu.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and lane helpers for the MEM-stage load/store unit.
// Byte-enable and offset helpers work on an 8-lane view; callers truncate.
package mem_stage_pkg;

  localparam logic [1:0] W_BYTE  = 2'b00;
  localparam logic [1:0] W_HALF  = 2'b01;
  localparam logic [1:0] W_WORD  = 2'b10;
  localparam logic [1:0] W_DWORD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RD
  } state_e;

  function automatic logic [7:0] be_gen(
    input logic [1:0] width,
    input logic [2:0] off
  );
    unique case (width)
      W_BYTE:  be_gen = 8'h01 << off;
      W_HALF:  be_gen = 8'h03 << off;
      W_WORD:  be_gen = 8'h0F << off;
      default: be_gen = 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [1:0] width,
    input logic [2:0] off
  );
    unique case (width)
      W_HALF:  misaligned = off[0];
      W_WORD:  misaligned = (off[1:0] != 2'b00);
      W_DWORD: misaligned = (off != 3'b000);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] align_off(
    input logic [1:0] width,
    input logic [2:0] off
  );
    unique case (width)
      W_HALF:  align_off = {off[2:1], 1'b0};
      W_WORD:  align_off = {off[2], 2'b00};
      W_DWORD: align_off = 3'b000;
      default: align_off = off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: lane shift followed by sign/zero extension.
import mem_stage_pkg::*;

module lsu_load_align #(
  parameter int NB_DATA = 32,
  parameter int NB_OFF  = $clog2(NB_DATA/8)
) (
  input  logic [NB_DATA-1:0] rdata_i,
  input  logic [NB_OFF-1:0]  off_i,
  input  logic [1:0]         width_i,
  input  logic               sign_i,
  output logic [NB_DATA-1:0] data_o
);

  logic [NB_DATA-1:0] sh;
  logic [5:0]         msb;
  logic               fill;

  always_comb begin
    sh = rdata_i >> {off_i, 3'b000};
    unique case (width_i)
      W_BYTE:  msb = 6'd7;
      W_HALF:  msb = 6'd15;
      W_WORD:  msb = 6'd31;
      default: msb = 6'(NB_DATA-1);
    endcase
    fill   = sign_i & sh[msb];
    data_o = sh;
    for (int i = 0; i < NB_DATA; i++) begin
      if (i > int'(msb)) data_o[i] = fill;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage with req/gnt/rvalid data-memory handshake and MEM/WB regs.
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned ops into traps.
import mem_stage_pkg::*;

module mem_stage_lsu #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_halt,
  input  logic                 i_valid,
  input  logic [NB_DATA-1:0]   i_result,
  input  logic [NB_DATA-1:0]   i_data4Mem,
  input  logic [1:0]           i_width,
  input  logic                 i_sign_flag,
  input  logic                 i_memRead,
  input  logic                 i_memWrite,
  input  logic                 i_regWrite,
  input  logic                 i_mem2reg,
  input  logic [NB_REG-1:0]    i_reg2write,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [NB_ADDR-1:0]   o_mem_addr,
  output logic [NB_DATA/8-1:0] o_mem_be,
  output logic [NB_DATA-1:0]   o_mem_wdata,
  input  logic                 i_mem_gnt,
  input  logic                 i_mem_rvalid,
  input  logic [NB_DATA-1:0]   i_mem_rdata,
  output logic                 o_stall,
  output logic [NB_DATA-1:0]   o_reg_read,
  output logic [NB_DATA-1:0]   o_ALUresult,
  output logic [NB_REG-1:0]    o_reg2write,
  output logic                 o_regWrite,
  output logic                 o_mem2reg,
  output logic                 o_wb_valid,
  output logic                 o_misalign
);

  localparam int NB_BYTES = NB_DATA/8;
  localparam int NB_OFF   = $clog2(NB_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [NB_DATA-1:0]  h_addr_q, h_addr_d;
  logic [NB_DATA-1:0]  h_wdata_q, h_wdata_d;
  logic [NB_BYTES-1:0] h_be_q, h_be_d;
  logic [2:0]          h_off_q, h_off_d;
  logic [1:0]          h_width_q, h_width_d;
  logic                h_sign_q, h_sign_d;
  logic                h_we_q, h_we_d;
  logic                h_rw_q, h_rw_d;
  logic                h_m2r_q, h_m2r_d;
  logic [NB_REG-1:0]   h_dst_q, h_dst_d;

  logic [NB_DATA-1:0]  rd_q, rd_d;
  logic [NB_DATA-1:0]  alu_q, alu_d;
  logic [NB_REG-1:0]   dst_q, dst_d;
  logic                rw_q, rw_d;
  logic                m2r_q, m2r_d;
  logic                wbv_q, wbv_d;
  logic                mis_q, mis_d;

  logic [2:0]          off_in, off_use;
  logic [7:0]          be8;
  logic [NB_DATA-1:0]  wdata_in, ld_data;
  logic                accept, memop, noop_in, mis_in;
  logic                done_st, done_ld;

  assign accept  = i_valid & ~i_halt;
  assign memop   = i_memRead | i_memWrite;
  assign off_in  = 3'(i_result[NB_OFF-1:0]);
  assign mis_in  = misaligned(i_width, off_in);
  assign noop_in = (NB_DATA == 32) && (i_width == W_DWORD);
  assign off_use = TRAP ? off_in : align_off(i_width, off_in);
  assign be8     = be_gen(i_width, off_use);

  always_comb begin
    unique case (i_width)
      W_BYTE:  wdata_in = {(NB_BYTES){i_data4Mem[7:0]}};
      W_HALF:  wdata_in = {(NB_DATA/16){i_data4Mem[15:0]}};
      W_WORD:  wdata_in = {(NB_DATA/32){i_data4Mem[31:0]}};
      default: wdata_in = i_data4Mem;
    endcase
  end

  lsu_load_align #(.NB_DATA(NB_DATA)) u_align (
    .rdata_i (i_mem_rdata),
    .off_i   (h_off_q[NB_OFF-1:0]),
    .width_i (h_width_q),
    .sign_i  (h_sign_q),
    .data_o  (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    h_addr_d  = h_addr_q;
    h_wdata_d = h_wdata_q;
    h_be_d    = h_be_q;
    h_off_d   = h_off_q;
    h_width_d = h_width_q;
    h_sign_d  = h_sign_q;
    h_we_d    = h_we_q;
    h_rw_d    = h_rw_q;
    h_m2r_d   = h_m2r_q;
    h_dst_d   = h_dst_q;
    rd_d      = rd_q;
    alu_d     = alu_q;
    dst_d     = dst_q;
    rw_d      = rw_q;
    m2r_d     = m2r_q;
    mis_d     = mis_q;
    wbv_d     = 1'b0;
    done_st   = 1'b0;
    done_ld   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (1'b1)
            (!memop || noop_in || (TRAP && mis_in)): begin
              rd_d  = '0;
              alu_d = i_result;
              dst_d = i_reg2write;
              rw_d  = i_regWrite & ~memop;
              m2r_d = i_mem2reg;
              mis_d = memop & ~noop_in & mis_in;
              wbv_d = 1'b1;
            end
            default: begin
              h_addr_d  = i_result;
              h_wdata_d = wdata_in;
              h_be_d    = be8[NB_BYTES-1:0];
              h_off_d   = off_use;
              h_width_d = i_width;
              h_sign_d  = i_sign_flag;
              h_we_d    = i_memWrite;
              h_rw_d    = i_regWrite;
              h_m2r_d   = i_mem2reg;
              h_dst_d   = i_reg2write;
              state_d   = S_REQ;
            end
          endcase
        end
      end
      S_REQ: begin
        if (i_mem_gnt) begin
          done_st = h_we_q;
          done_ld = ~h_we_q & i_mem_rvalid;
          if (!h_we_q && !i_mem_rvalid) state_d = S_WAIT_RD;
        end
      end
      S_WAIT_RD: done_ld = i_mem_rvalid;
      default:   state_d = S_IDLE;
    endcase
    if (done_st || done_ld) begin
      rd_d    = done_ld ? ld_data : '0;
      alu_d   = h_addr_q;
      dst_d   = h_dst_q;
      rw_d    = h_rw_q & done_ld;
      m2r_d   = h_m2r_q;
      mis_d   = 1'b0;
      wbv_d   = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      h_addr_q  <= '0;
      h_wdata_q <= '0;
      h_be_q    <= '0;
      h_off_q   <= '0;
      h_width_q <= '0;
      h_sign_q  <= 1'b0;
      h_we_q    <= 1'b0;
      h_rw_q    <= 1'b0;
      h_m2r_q   <= 1'b0;
      h_dst_q   <= '0;
      rd_q      <= '0;
      alu_q     <= '0;
      dst_q     <= '0;
      rw_q      <= 1'b0;
      m2r_q     <= 1'b0;
      wbv_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_addr_q  <= h_addr_d;
      h_wdata_q <= h_wdata_d;
      h_be_q    <= h_be_d;
      h_off_q   <= h_off_d;
      h_width_q <= h_width_d;
      h_sign_q  <= h_sign_d;
      h_we_q    <= h_we_d;
      h_rw_q    <= h_rw_d;
      h_m2r_q   <= h_m2r_d;
      h_dst_q   <= h_dst_d;
      rd_q      <= rd_d;
      alu_q     <= alu_d;
      dst_q     <= dst_d;
      rw_q      <= rw_d;
      m2r_q     <= m2r_d;
      wbv_q     <= wbv_d;
      mis_q     <= mis_d;
    end
  end

  assign o_stall     = (state_q != S_IDLE);
  assign o_mem_req   = (state_q == S_REQ);
  assign o_mem_we    = o_mem_req & h_we_q;
  assign o_mem_addr  = h_addr_q[NB_ADDR+NB_OFF-1:NB_OFF];
  assign o_mem_be    = h_be_q;
  assign o_mem_wdata = h_wdata_q;
  assign o_reg_read  = rd_q;
  assign o_ALUresult = alu_q;
  assign o_reg2write = dst_q;
  assign o_regWrite  = rw_q;
  assign o_mem2reg   = m2r_q;
  assign o_wb_valid  = wbv_q;
  assign o_misalign  = mis_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (NB_DATA=32).
// Expected values are hand-computed from the stage behaviour.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_halt, i_valid;
  logic [31:0] i_result, i_data4Mem;
  logic [1:0]  i_width;
  logic        i_sign_flag, i_memRead, i_memWrite;
  logic        i_regWrite, i_mem2reg;
  logic [4:0]  i_reg2write;
  logic        o_mem_req, o_mem_we;
  logic [7:0]  o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt, i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_stall;
  logic [31:0] o_reg_read, o_ALUresult;
  logic [4:0]  o_reg2write;
  logic        o_regWrite, o_mem2reg, o_wb_valid, o_misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.NB_DATA(32), .NB_ADDR(8), .NB_REG(5)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_halt(i_halt),
    .i_valid(i_valid), .i_result(i_result),
    .i_data4Mem(i_data4Mem), .i_width(i_width),
    .i_sign_flag(i_sign_flag), .i_memRead(i_memRead),
    .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
    .i_mem2reg(i_mem2reg), .i_reg2write(i_reg2write),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
    .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_stall(o_stall), .o_reg_read(o_reg_read),
    .o_ALUresult(o_ALUresult), .o_reg2write(o_reg2write),
    .o_regWrite(o_regWrite), .o_mem2reg(o_mem2reg),
    .o_wb_valid(o_wb_valid), .o_misalign(o_misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    i_halt = 0; i_valid = 0; i_result = 0; i_data4Mem = 0;
    i_width = 0; i_sign_flag = 0; i_memRead = 0;
    i_memWrite = 0; i_regWrite = 0; i_mem2reg = 0;
    i_reg2write = 0; i_mem_gnt = 0; i_mem_rvalid = 0;
    i_mem_rdata = 0;
  endtask

  task automatic issue(input logic rd, input logic wr,
                       input logic [1:0] w, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    i_valid = 1; i_memRead = rd; i_memWrite = wr;
    i_width = w; i_sign_flag = s; i_result = a;
    i_data4Mem = d; i_regWrite = rd; i_mem2reg = rd;
    i_reg2write = 5'd9;
    tick();
    i_valid = 0; i_memRead = 0; i_memWrite = 0;
  endtask

  task automatic test_reset();
    idle_in();
    i_rst_n = 0;
    #12;
    total++;
    if ({o_mem_req, o_stall, o_wb_valid, o_regWrite} !== 4'b0 ||
        o_ALUresult !== 32'h0 || o_reg_read !== 32'h0) begin
      bad++;
      $display("FAIL reset req=%b stall=%b wbv=%b alu=%h rd=%h exp 0",
               o_mem_req, o_stall, o_wb_valid, o_ALUresult, o_reg_read);
    end
    @(negedge clk);
    i_rst_n = 1;
    tick();
  endtask

  task automatic test_alu();
    i_valid = 1; i_result = 32'h1234; i_regWrite = 1;
    i_reg2write = 5'd3;
    tick();
    i_valid = 0; i_regWrite = 0;
    total++;
    if (o_ALUresult !== 32'h1234 || o_wb_valid !== 1'b1 ||
        o_stall !== 1'b0 || o_regWrite !== 1'b1 ||
        o_reg2write !== 5'd3) begin
      bad++;
      $display("FAIL alu alu=%h wbv=%b stall=%b rw=%b dst=%0d exp 1234 1 0 1 3",
               o_ALUresult, o_wb_valid, o_stall, o_regWrite, o_reg2write);
    end
    tick();
    total++;
    if (o_wb_valid !== 1'b0 || o_ALUresult !== 32'h1234) begin
      bad++;
      $display("FAIL bubble wbv=%b alu=%h exp 0 1234",
               o_wb_valid, o_ALUresult);
    end
  endtask

  task automatic test_halt();
    i_halt = 1; i_valid = 1; i_result = 32'h5555;
    tick();
    tick();
    total++;
    if (o_wb_valid !== 1'b0 || o_ALUresult !== 32'h1234 ||
        o_stall !== 1'b0) begin
      bad++;
      $display("FAIL halt wbv=%b alu=%h stall=%b exp 0 1234 0",
               o_wb_valid, o_ALUresult, o_stall);
    end
    i_halt = 0; i_valid = 0;
  endtask

  task automatic test_store_byte();
    i_regWrite = 1;
    issue(0, 1, 2'b00, 0, 32'h6, 32'h0000_00AB);
    i_regWrite = 1;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1 ||
          o_mem_be !== 4'b0100 || o_mem_wdata !== 32'hABABABAB ||
          o_mem_addr !== 8'd1 || o_stall !== 1'b1) begin
        bad++;
        $display("FAIL sb_req c=%0d req=%b we=%b be=%b wd=%h a=%0d st=%b exp 1 1 0100 ABABABAB 1 1",
                 c, o_mem_req, o_mem_we, o_mem_be, o_mem_wdata,
                 o_mem_addr, o_stall);
      end
      if (c < 2) tick();
    end
    i_mem_gnt = 1;
    tick();
    i_mem_gnt = 0; i_regWrite = 0;
    total++;
    if (o_wb_valid !== 1'b1 || o_regWrite !== 1'b0 ||
        o_stall !== 1'b0 || o_mem_req !== 1'b0 ||
        o_ALUresult !== 32'h6) begin
      bad++;
      $display("FAIL sb_done wbv=%b rw=%b st=%b req=%b alu=%h exp 1 0 0 0 6",
               o_wb_valid, o_regWrite, o_stall, o_mem_req, o_ALUresult);
    end
  endtask

  task automatic test_load_half(input logic s, input logic [31:0] exp);
    issue(1, 0, 2'b01, s, 32'h2, 32'h0);
    total++;
    if (o_mem_be !== 4'b1100 || o_mem_we !== 1'b0 ||
        o_mem_req !== 1'b1) begin
      bad++;
      $display("FAIL lh_req be=%b we=%b req=%b exp 1100 0 1",
               o_mem_be, o_mem_we, o_mem_req);
    end
    i_mem_gnt = 1;
    tick();
    i_mem_gnt = 0;
    tick();
    total++;
    if (o_stall !== 1'b1 || o_mem_req !== 1'b0 ||
        o_wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL lh_wait st=%b req=%b wbv=%b exp 1 0 0",
               o_stall, o_mem_req, o_wb_valid);
    end
    i_mem_rvalid = 1; i_mem_rdata = 32'h8001_1234;
    tick();
    i_mem_rvalid = 0;
    total++;
    if (o_reg_read !== exp || o_wb_valid !== 1'b1 ||
        o_regWrite !== 1'b1 || o_reg2write !== 5'd9 ||
        o_mem2reg !== 1'b1 || o_stall !== 1'b0) begin
      bad++;
      $display("FAIL lh s=%b rd=%h wbv=%b rw=%b dst=%0d st=%b exp %h 1 1 9 0",
               s, o_reg_read, o_wb_valid, o_regWrite, o_reg2write,
               o_stall, exp);
    end
  endtask

  task automatic test_back_to_back();
    issue(1, 0, 2'b00, 1, 32'h1, 32'h0);
    total++;
    if (o_wb_valid !== 1'b0 || o_stall !== 1'b1) begin
      bad++;
      $display("FAIL lb_first wbv=%b st=%b exp 0 1", o_wb_valid, o_stall);
    end
    i_mem_gnt = 1; i_mem_rvalid = 1; i_mem_rdata = 32'h1234_F0AB;
    tick();
    i_mem_gnt = 0; i_mem_rvalid = 0;
    total++;
    if (o_reg_read !== 32'hFFFF_FFF0 || o_wb_valid !== 1'b1 ||
        o_stall !== 1'b0) begin
      bad++;
      $display("FAIL lb_fast rd=%h wbv=%b st=%b exp FFFFFFF0 1 0",
               o_reg_read, o_wb_valid, o_stall);
    end
  endtask

  task automatic test_noop_dword();
    issue(1, 0, 2'b11, 0, 32'h40, 32'h0);
    total++;
    if (o_wb_valid !== 1'b1 || o_regWrite !== 1'b0 ||
        o_stall !== 1'b0 || o_mem_req !== 1'b0) begin
      bad++;
      $display("FAIL noop wbv=%b rw=%b st=%b req=%b exp 1 0 0 0",
               o_wb_valid, o_regWrite, o_stall, o_mem_req);
    end
  endtask

  task automatic test_misalign();
    issue(1, 0, 2'b10, 0, 32'h3, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    total++;
    if (o_mem_req !== 1'b0 || o_misalign !== 1'b1 ||
        o_regWrite !== 1'b0 || o_wb_valid !== 1'b1) begin
      bad++;
      $display("FAIL lw_trap req=%b mis=%b rw=%b wbv=%b exp 0 1 0 1",
               o_mem_req, o_misalign, o_regWrite, o_wb_valid);
    end
`else
    total++;
    if (o_mem_req !== 1'b1 || o_mem_be !== 4'b1111 ||
        o_mem_addr !== 8'd0 || o_misalign !== 1'b0) begin
      bad++;
      $display("FAIL lw_mis req=%b be=%b a=%0d mis=%b exp 1 1111 0 0",
               o_mem_req, o_mem_be, o_mem_addr, o_misalign);
    end
    i_mem_gnt = 1; i_mem_rvalid = 1; i_mem_rdata = 32'hDEAD_BEEF;
    tick();
    i_mem_gnt = 0; i_mem_rvalid = 0;
    total++;
    if (o_reg_read !== 32'hDEAD_BEEF || o_wb_valid !== 1'b1) begin
      bad++;
      $display("FAIL lw_mis_rd rd=%h wbv=%b exp DEADBEEF 1",
               o_reg_read, o_wb_valid);
    end
`endif
  endtask

  task automatic test_reset_midop();
    issue(1, 0, 2'b10, 0, 32'h8, 32'h0);
    i_mem_gnt = 1;
    tick();
    i_mem_gnt = 0;
    total++;
    if (o_stall !== 1'b1) begin
      bad++;
      $display("FAIL wait_entry st=%b exp 1", o_stall);
    end
    i_rst_n = 0;
    #1;
    total++;
    if (o_mem_req !== 1'b0 || o_stall !== 1'b0 ||
        o_ALUresult !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid req=%b st=%b alu=%h exp 0 0 0",
               o_mem_req, o_stall, o_ALUresult);
    end
    @(negedge clk);
    i_rst_n = 1;
    i_mem_rvalid = 1; i_mem_rdata = 32'hCAFE_F00D;
    tick();
    i_mem_rvalid = 0;
    tick();
    total++;
    if (o_wb_valid !== 1'b0 || o_reg_read !== 32'h0 ||
        o_stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_rvalid wbv=%b rd=%h st=%b exp 0 0 0",
               o_wb_valid, o_reg_read, o_stall);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_halt();
    test_store_byte();
    test_load_half(1'b1, 32'hFFFF_8001);
    test_load_half(1'b0, 32'h0000_8001);
    test_back_to_back();
    test_noop_dword();
    test_misalign();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
